i2c_slave_mem: RTL and testbench
================================

Name: i2c_slave_mem

Overview:
- Synthesizable I2C responder (target) emulating a 24xx02-style 256-byte EEPROM.
- Sits at the far end of the I2C bus from the existing EEPROM master controller; replaces the behavioural memory model on FPGA builds and lets the master be tested board-to-board.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain only.
- Storage is external, reached through a simple synchronous memory port.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched against the first byte after START.
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W and the address wraps.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in before edge detection (minimum 2).

Ports:
- clk  in  1  system clock (50 MHz nominal, at least 20x SCL rate)
- rst_n  in  1  asynchronous active-low reset
- scl_in  in  1  sampled SCL pad (bus pulled up externally)
- sda_in  in  1  sampled SDA pad
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad tri-stated)
- mem_addr  out  ADDR_W  word address to storage
- mem_we  out  1  one-cycle write strobe
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid one clk after mem_addr is presented
- busy  out  1  high from a matched address ACK until STOP/START/NACK

Behaviour:
- Reset: sda_oe=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, state IDLE, internal address pointer=0. Asserting rst_n low mid-transfer releases SDA immediately.
- Front end: sync SCL/SDA through SYNC_STAGES flops. scl_rise/scl_fall are one-clk pulses. START = SDA fall while SCL high; STOP = SDA rise while SCL high. Data bits are sampled on scl_rise.
- START (including repeated START) in any state -> DEV_ADDR, bit count 0, sda_oe released. STOP in any state -> IDLE, busy=0. Any pending write has already completed.
- States: IDLE, DEV_ADDR, ACK_DEV, WORD_ADDR, ACK_WORD, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE.
- DEV_ADDR: shift 8 bits MSB-first. On the 8th scl_rise: if byte[7:1]==DEV_ADDR -> ACK_DEV, else IGNORE (SDA never driven until next START/STOP).
- ACK drive: on the scl_fall after bit 8, set sda_oe=1. Release it on the following scl_fall (the end of the 9th clock).
- ACK_DEV: R/W=0 -> WORD_ADDR. R/W=1 -> issue mem_addr=pointer, latch mem_rdata one clk later, then RD_DATA (current-address read).
- WORD_ADDR: 8 bits into pointer, ACK, -> WR_DATA. Only ADDR_W LSBs are kept when ADDR_W<8.
- WR_DATA: after 8 bits, pulse mem_we for one clk with mem_addr=pointer and mem_wdata=byte, ACK, pointer+=1 (wrap at 2**ADDR_W-1 -> 0), then stay in WR_DATA. No page-boundary rollover: the full address space is linear.
- Random read: master writes the word address, then repeated START with R/W=1. The pointer is retained across the START.
- RD_DATA: drive the MSB on the scl_fall ending the ACK. Each subsequent scl_fall presents the next bit; sda_oe = ~bit. Release on the scl_fall after bit 0.
- RD_ACK: sample master ACK on scl_rise. ACK (0) -> pointer+=1 (wrap), fetch the next byte, back to RD_DATA. NACK (1) -> IGNORE (bus released; wait for STOP).
- The pointer increments only after a completed data byte, never on address bytes.
- SDA transitions from sda_oe always occur at least one clk after scl_fall; SDA is never changed while SCL is high.
- busy=1 from ACK_DEV entry until IDLE/IGNORE/new DEV_ADDR.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enumeration localparams;
  - the R/W bit encoding;
  - the default EEPROM address 7'h50, shared with the master controller and the bench.
- One sub-module, i2c_bus_sync: synchronizers plus scl_rise/scl_fall/start/stop pulse generation. Reusable by the master's clock-stretch detection.

Test Plan:
- Byte write: START, 0xA0, addr 0x10, data 0x5A, STOP -> three ACKs; one mem_we pulse with mem_addr=0x10 and mem_wdata=0x5A; busy falls after STOP.
- Random read: memory[0x10]=0x5A; START 0xA0, 0x10, repeated START 0xA1, master NACK, STOP -> SDA carries 0x5A MSB-first; sda_oe=0 after the NACK.
- Sequential write wrap: write addr 0xFE with data 0x11, 0x22, 0x33 -> mem_we at 0xFE, 0xFF, 0x00 in order.
- Address mismatch: START 0xA2 (0x51) -> no ACK (sda_oe stays 0 throughout); mem_we never pulses; busy stays 0.
- Current-address sequential read: pointer=0x20; START 0xA1, master ACKs 2 bytes then NACKs -> bytes from 0x20, 0x21, 0x22; pointer ends at 0x22.
- Reset mid-read: drop rst_n while sda_oe=1 during RD_DATA -> sda_oe=0 within the same clk, pointer=0, and the next transfer decodes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W bit values and the default
// EEPROM target address used by the master controller, the responder and benches.
package i2c_pkg;

  localparam logic [6:0] EEPROM_DEV_ADDR = 7'h50;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_WORD_ADDR,
    ST_ACK_WORD,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with one-clk scl_rise/scl_fall and START/STOP pulses.
// SYNC_STAGES must be at least 2.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_q;
  logic                   r_sda_q;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Reset to the idle-bus level so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value of
      // the previous one, which is what turns this into a real shift chain.
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_q    <= w_scl;
      r_sda_q    <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_q;
  assign o_scl_fall = ~w_scl & r_scl_q;
  assign o_start    = r_scl_q & w_scl & r_sda_q & ~w_sda;
  assign o_stop     = r_scl_q & w_scl & ~r_sda_q & w_sda;

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C target emulating a 24xx02-style EEPROM on top of an external synchronous
// memory port; SDA is driven open-drain through sda_oe only.
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = EEPROM_DEV_ADDR,
  parameter int         ADDR_W      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic [7:0] w_byte;

  state_e            r_state;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_shift;
  logic [6:0]        r_tx;
  logic [7:0]        r_rd_byte;
  logic [1:0]        r_fetch;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_rw;
  logic              r_ack_on;
  logic              r_sda_oe;
  logic              r_busy;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_byte = {r_shift, w_sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_rd_byte   <= '0;
      r_fetch     <= '0;
      r_ptr       <= '0;
      r_rw        <= RW_WRITE;
      r_ack_on    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      // Read fetch: address goes out, memory answers next clk, latched the clk after.
      r_fetch  <= {r_fetch[0], 1'b0};
      if (r_fetch[1]) r_rd_byte <= mem_rdata;

      if (w_start) begin
        r_state   <= ST_DEV_ADDR;
        r_bit_cnt <= '0;
        r_ack_on  <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_ack_on <= 1'b0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_IGNORE: ;

          ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_state == ST_DEV_ADDR) begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    r_state <= ST_ACK_DEV;
                    r_busy  <= 1'b1;
                    r_rw    <= w_byte[0];
                    if (w_byte[0] == RW_READ) begin
                      r_mem_addr <= r_ptr;
                      r_fetch    <= 2'b01;
                    end
                  end else begin
                    r_state <= ST_IGNORE;
                  end
                end else if (r_state == ST_WORD_ADDR) begin
                  r_ptr   <= w_byte[ADDR_W-1:0];
                  r_state <= ST_ACK_WORD;
                end else begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_ptr;
                  r_mem_wdata <= w_byte;
                  r_ptr       <= r_ptr + PTR_ONE;
                  r_state     <= ST_ACK_WR;
                end
              end
            end
          end

          // First scl_fall pulls SDA for the ACK, the second one ends the 9th clock.
          ST_ACK_DEV, ST_ACK_WORD, ST_ACK_WR: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_ack_on <= 1'b1;
                r_sda_oe <= 1'b1;
              end else begin
                r_ack_on <= 1'b0;
                r_sda_oe <= 1'b0;
                if (r_state == ST_ACK_DEV && r_rw == RW_READ) begin
                  r_state   <= ST_RD_DATA;
                  r_bit_cnt <= '0;
                  r_tx      <= r_rd_byte[6:0];
                  r_sda_oe  <= ~r_rd_byte[7];
                end else if (r_state == ST_ACK_DEV) begin
                  r_state <= ST_WORD_ADDR;
                end else begin
                  r_state <= ST_WR_DATA;
                end
              end
            end
          end

          ST_RD_DATA: begin
            if (w_scl_fall) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_RD_ACK;
              end else begin
                r_sda_oe <= ~r_tx[6];
                r_tx     <= {r_tx[5:0], 1'b0};
              end
            end
          end

          // r_ack_on here marks "master ACKed, next byte goes out on the coming fall".
          ST_RD_ACK: begin
            if (w_scl_rise && !r_ack_on) begin
              if (w_sda) begin
                r_state <= ST_IGNORE;
                r_busy  <= 1'b0;
              end else begin
                r_ptr      <= r_ptr + PTR_ONE;
                r_mem_addr <= r_ptr + PTR_ONE;
                r_fetch    <= 2'b01;
                r_ack_on   <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_on) begin
              r_ack_on  <= 1'b0;
              r_state   <= ST_RD_DATA;
              r_bit_cnt <= '0;
              r_tx      <= r_rd_byte[6:0];
              r_sda_oe  <= ~r_rd_byte[7];
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master, behavioural memory and a
// write-strobe scoreboard.
module tb_i2c_slave_mem;
  import i2c_pkg::*;

  localparam int Q = 10;  // clks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy;
  logic       sda_line;

  logic [7:0] mem [0:255];

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t wr_q[$];

  typedef struct {
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  logic oe_seen;
  logic busy_seen;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (wr_q.size() == 0) begin
        check("unexpected_we", {mem_addr, mem_wdata}, 32'h0);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("we_addr", mem_addr, e.addr);
        check("we_data", mem_wdata, e.data);
      end
    end
    if (sda_oe) oe_seen = 1'b1;
    if (busy)   busy_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b1; qw();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; qw();
      scl_m = 1'b1; qw(); qw();
      scl_m = 1'b0; qw();
    end
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    ack = sda_line; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      qw();
      scl_m = 1'b1; qw();
      d[i] = sda_line; qw();
      scl_m = 1'b0;
    end
    qw();
    sda_m = nack; qw();
    scl_m = 1'b1; qw(); qw();
    scl_m = 1'b0; qw();
    sda_m = 1'b1;
  endtask

  task automatic send(input string name, input logic [7:0] b, input logic exp_ack);
    logic ack;
    write_byte(b, ack);
    check(name, ack, exp_ack);
  endtask

  task automatic random_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    logic [7:0] d;
    bus_start();
    send({name, "_ack_dw"}, 8'hA0, 1'b0);
    send({name, "_ack_wa"}, a, 1'b0);
    bus_start();
    send({name, "_ack_dr"}, 8'hA1, 1'b0);
    read_byte(1'b1, d);
    check({name, "_data"}, d, exp);
    check({name, "_oe_after_nack"}, sda_oe, 1'b0);
    bus_stop();
  endtask

  initial begin
    vec_t vecs[4];
    logic [7:0] d;
    logic       ok;

    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;

    vecs[0] = '{waddr: 8'h00, wdata: 8'hC3, exp_rdata: 8'hC3};
    vecs[1] = '{waddr: 8'h7F, wdata: 8'h81, exp_rdata: 8'h81};
    vecs[2] = '{waddr: 8'hFF, wdata: 8'h0F, exp_rdata: 8'h0F};
    vecs[3] = '{waddr: 8'h80, wdata: 8'hFF, exp_rdata: 8'hFF};

    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte write
    bus_start();
    send("bw_ack_dev", 8'hA0, 1'b0);
    check("bw_busy", busy, 1'b1);
    send("bw_ack_word", 8'h10, 1'b0);
    wr_q.push_back('{addr: 8'h10, data: 8'h5A});
    send("bw_ack_data", 8'h5A, 1'b0);
    bus_stop();
    check("bw_busy_after_stop", busy, 1'b0);
    check("bw_queue_empty", wr_q.size(), 0);

    random_read(8'h10, 8'h5A, "rr");

    for (int i = 0; i < 4; i++) begin
      bus_start();
      send($sformatf("tbl%0d_ack_dev", i), 8'hA0, 1'b0);
      send($sformatf("tbl%0d_ack_word", i), vecs[i].waddr, 1'b0);
      wr_q.push_back('{addr: vecs[i].waddr, data: vecs[i].wdata});
      send($sformatf("tbl%0d_ack_data", i), vecs[i].wdata, 1'b0);
      bus_stop();
      random_read(vecs[i].waddr, vecs[i].exp_rdata, $sformatf("tbl%0d_rd", i));
    end

    // Sequential write across the top of the address space
    bus_start();
    send("wrap_ack_dev", 8'hA0, 1'b0);
    send("wrap_ack_word", 8'hFE, 1'b0);
    wr_q.push_back('{addr: 8'hFE, data: 8'h11});
    send("wrap_ack_d0", 8'h11, 1'b0);
    wr_q.push_back('{addr: 8'hFF, data: 8'h22});
    send("wrap_ack_d1", 8'h22, 1'b0);
    wr_q.push_back('{addr: 8'h00, data: 8'h33});
    send("wrap_ack_d2", 8'h33, 1'b0);
    bus_stop();
    check("wrap_queue_empty", wr_q.size(), 0);

    // Foreign device address: no ACK, no write, never busy
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    send("mis_nack_dev", 8'hA2, 1'b1);
    send("mis_nack_b1", 8'h10, 1'b1);
    send("mis_nack_b2", 8'h99, 1'b1);
    bus_stop();
    check("mis_oe_seen", oe_seen, 1'b0);
    check("mis_busy_seen", busy_seen, 1'b0);

    // Current-address sequential read from 0x20
    mem[8'h20] <= 8'hA5;
    mem[8'h21] <= 8'h3C;
    mem[8'h22] <= 8'h96;
    bus_start();
    send("seq_ack_dw", 8'hA0, 1'b0);
    send("seq_ack_wa", 8'h20, 1'b0);
    bus_stop();
    bus_start();
    send("seq_ack_dr", 8'hA1, 1'b0);
    read_byte(1'b0, d);
    check("seq_b0", d, 8'hA5);
    read_byte(1'b0, d);
    check("seq_b1", d, 8'h3C);
    read_byte(1'b1, d);
    check("seq_b2", d, 8'h96);
    check("seq_busy_after_nack", busy, 1'b0);
    bus_stop();
    bus_start();
    send("seq_ptr_ack", 8'hA1, 1'b0);
    read_byte(1'b1, d);
    check("seq_ptr_end", d, 8'h96);
    bus_stop();

    // Reset while the responder is driving a read bit low
    mem[8'h30] <= 8'h12;
    bus_start();
    send("rst_ack_dw", 8'hA0, 1'b0);
    send("rst_ack_wa", 8'h30, 1'b0);
    bus_start();
    send("rst_ack_dr", 8'hA1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (sda_oe) ok = 1'b1;
      else @(negedge clk);
    end
    check("rst_wait_oe", ok, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", sda_oe, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_addr", mem_addr, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_start();
    send("post_rst_ack", 8'hA1, 1'b0);
    read_byte(1'b1, d);
    check("post_rst_data", d, 8'h33);
    bus_stop();
    check("final_queue_empty", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
